valu_issue_seq: RTL and testbench
=================================

VALU_ISSUE_SEQ -- requirements
Module: valu_issue_seq

Interface
REQ-001 SHALL have parameter LANES, default 4, elements processed per beat (power of two, 1..16).
REQ-002 SHALL have parameter VLEN, default 128, maximum vector length in elements; VL_W = $clog2(VLEN)+1.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  instruction offered.
REQ-006 SHALL have port in_ready  output  1  high when the block can accept an instruction.
REQ-007 SHALL have port funct6  input  6  vector ALU opcode field.
REQ-008 SHALL have port funct3  input  3  operand category: 000 OPIVV, 100 OPIVX, 011 OPIVI.
REQ-009 SHALL have port vl  input  VL_W  element count, 0..VLEN.
REQ-010 SHALL have port vm  input  1  0 = masked op; passed through as out_masked.
REQ-011 SHALL have ports out_valid output 1, out_ready input 1  beat handshake to the lane datapath.
REQ-012 SHALL have ports out_aluop output 4 (ALUOp code), out_src_sel output 2 (0 vector, 1 scalar, 2 immediate), out_masked output 1.
REQ-013 SHALL have ports out_elem_idx output VL_W (first element of beat), out_lane_en output LANES, out_last output 1.
REQ-014 SHALL have port illegal  output  1  one-cycle pulse on acceptance of an unsupported encoding.

Function
REQ-015 SHALL implement FSM states IDLE and ISSUE; in_ready = 1 only in IDLE.
REQ-016 SHALL decode funct6: 000000 ADD, 000010 SUB, 001001 AND, 001010 OR, 001011 XOR, 100101 SLL, 101000 SRL, 101001 SRA; all other funct6 illegal.
REQ-017 SHALL treat funct3 outside {000,100,011}, and SUB with funct3=011, as illegal.
REQ-018 SHALL, on in_valid&&in_ready with illegal encoding, pulse illegal the next cycle, issue no beats, remain IDLE.
REQ-019 SHALL, on accepted legal instruction with vl=0, issue no beats, assert nothing, remain IDLE.
REQ-020 SHALL, on accepted legal instruction with vl>0, latch opcode fields, vm and vl, set out_elem_idx=0, enter ISSUE; first beat out_valid the following cycle (latency 1).
REQ-021 SHALL in ISSUE hold out_valid=1 and all out_* stable until out_valid&&out_ready.
REQ-022 SHALL on each beat handshake advance out_elem_idx by LANES.
REQ-023 SHALL drive out_lane_en[i] = (out_elem_idx+i < vl_latched).
REQ-024 SHALL drive out_last = (out_elem_idx+LANES >= vl_latched); handshake with out_last returns FSM to IDLE.
REQ-025 SHALL issue exactly ceil(vl/LANES) beats per instruction; vl=VLEN issues VLEN/LANES beats with no index overflow.
REQ-026 SHALL ignore in_valid and input field changes while in ISSUE.
REQ-027 SHALL keep out_valid=0 in IDLE; one idle cycle separates consecutive instructions.

Reset
REQ-028 SHALL on reset force state IDLE, out_valid=0, out_last=0, illegal=0, out_elem_idx=0, out_lane_en=0, out_aluop=0, out_src_sel=0, out_masked=0.
REQ-029 SHALL on reset during ISSUE abandon the instruction: no further beats, in_ready=1 the cycle after reset deasserts.

Structure
REQ-030 SHALL take ALUOp codes (ADD, SUB, AND, OR, XOR, SLL, SRL, SRA) from the shared constants header; new FUNCT6_V* and FUNCT3_OPIV* constants SHALL be added there.
REQ-031 SHALL place funct6/funct3 decode in combinational sub-module valu_decode (outputs aluop, src_sel, legal); sequencing stays in valu_issue_seq.

Verification
REQ-032 SHALL cover: LANES=4, vadd.vv vl=10, out_ready=1 -> 3 beats, elem_idx 0/4/8, lane_en 1111/1111/0011, out_last on beat 3.
REQ-033 SHALL cover: vsra.vi vl=4 with out_ready low 3 cycles -> single beat, aluop=SRA, src_sel=2, outputs stable while stalled, out_last=1.
REQ-034 SHALL cover: funct6=111111 or vsub.vi -> illegal pulse 1 cycle, out_valid never high, in_ready stays 1.
REQ-035 SHALL cover: vxor.vx vl=0 -> no beats, no illegal, in_ready continuously 1.
REQ-036 SHALL cover: vl=128 (VLEN) -> 32 beats, final elem_idx=124, lane_en=1111, out_last on beat 32.
REQ-037 SHALL cover: reset asserted at beat 2 of vl=16 -> out_valid 0 next cycle, new vand.vv vl=4 then completes normally.

Source files
------------

// File: rtl/valu_issue_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : valu_issue_seq_pkg
// Brief  : Shared constants for the vector ALU issue sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package valu_issue_seq_pkg;

  localparam logic [3:0] ALUOP_ADD = 4'd0;
  localparam logic [3:0] ALUOP_SUB = 4'd1;
  localparam logic [3:0] ALUOP_AND = 4'd2;
  localparam logic [3:0] ALUOP_OR  = 4'd3;
  localparam logic [3:0] ALUOP_XOR = 4'd4;
  localparam logic [3:0] ALUOP_SLL = 4'd5;
  localparam logic [3:0] ALUOP_SRL = 4'd6;
  localparam logic [3:0] ALUOP_SRA = 4'd7;

  localparam logic [5:0] FUNCT6_VADD = 6'b000000;
  localparam logic [5:0] FUNCT6_VSUB = 6'b000010;
  localparam logic [5:0] FUNCT6_VAND = 6'b001001;
  localparam logic [5:0] FUNCT6_VOR  = 6'b001010;
  localparam logic [5:0] FUNCT6_VXOR = 6'b001011;
  localparam logic [5:0] FUNCT6_VSLL = 6'b100101;
  localparam logic [5:0] FUNCT6_VSRL = 6'b101000;
  localparam logic [5:0] FUNCT6_VSRA = 6'b101001;

  localparam logic [2:0] FUNCT3_OPIVV = 3'b000;
  localparam logic [2:0] FUNCT3_OPIVX = 3'b100;
  localparam logic [2:0] FUNCT3_OPIVI = 3'b011;

  localparam logic [1:0] SRC_VECTOR = 2'd0;
  localparam logic [1:0] SRC_SCALAR = 2'd1;
  localparam logic [1:0] SRC_IMM    = 2'd2;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/valu_issue_seq_decode.sv
`default_nettype none
// ============================================================================
// Module : valu_decode
// Brief  : Combinational funct6/funct3 decode into ALUOp, operand source, legal.
// Rev    : 1.0  initial release
// ============================================================================
module valu_decode
  import valu_issue_seq_pkg::*;
(
  input  logic [5:0] funct6,
  input  logic [2:0] funct3,
  output logic [3:0] aluop,
  output logic [1:0] src_sel,
  output logic       legal
);

  always_comb begin
    aluop   = ALUOP_ADD;
    src_sel = SRC_VECTOR;
    legal   = 1'b1;

    case (funct6)
      FUNCT6_VADD: aluop = ALUOP_ADD;
      FUNCT6_VSUB: aluop = ALUOP_SUB;
      FUNCT6_VAND: aluop = ALUOP_AND;
      FUNCT6_VOR:  aluop = ALUOP_OR;
      FUNCT6_VXOR: aluop = ALUOP_XOR;
      FUNCT6_VSLL: aluop = ALUOP_SLL;
      FUNCT6_VSRL: aluop = ALUOP_SRL;
      FUNCT6_VSRA: aluop = ALUOP_SRA;
      default:     legal = 1'b0;
    endcase

    case (funct3)
      FUNCT3_OPIVV: src_sel = SRC_VECTOR;
      FUNCT3_OPIVX: src_sel = SRC_SCALAR;
      FUNCT3_OPIVI: src_sel = SRC_IMM;
      default:      legal   = 1'b0;
    endcase

    // There is no vsub.vi form; reverse-subtract covers immediates.
    if (funct6 == FUNCT6_VSUB && funct3 == FUNCT3_OPIVI) begin
      legal = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/valu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module : valu_issue_seq
// Brief  : Accepts one vector ALU instruction and issues it as LANES-wide beats.
// Rev    : 1.0  initial release
// ============================================================================
module valu_issue_seq
  import valu_issue_seq_pkg::*;
#(
  parameter  int LANES = 4,
  parameter  int VLEN  = 128,
  localparam int VL_W  = $clog2(VLEN) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct6,
  input  logic [2:0]       funct3,
  input  logic [VL_W-1:0]  vl,
  input  logic             vm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_aluop,
  output logic [1:0]       out_src_sel,
  output logic             out_masked,
  output logic [VL_W-1:0]  out_elem_idx,
  output logic [LANES-1:0] out_lane_en,
  output logic             out_last,
  output logic             illegal
);

  // One extra bit so idx + LANES never wraps when vl == VLEN.
  localparam int W1 = VL_W + 1;

  state_e          state_q, state_d;
  logic [3:0]      aluop_q, aluop_d;
  logic [1:0]      src_sel_q, src_sel_d;
  logic            masked_q, masked_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [VL_W-1:0] idx_q, idx_d;
  logic            illegal_q, illegal_d;

  logic [3:0]       w_dec_aluop;
  logic [1:0]       w_dec_src_sel;
  logic             w_dec_legal;
  logic             w_issuing;
  logic             w_last;
  logic [LANES-1:0] w_lane_en;

  valu_decode u_decode (
    .funct6  (funct6),
    .funct3  (funct3),
    .aluop   (w_dec_aluop),
    .src_sel (w_dec_src_sel),
    .legal   (w_dec_legal)
  );

  assign w_issuing = (state_q == S_ISSUE);
  assign w_last    = ({1'b0, idx_q} + W1'(LANES)) >= {1'b0, vl_q};

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_en[g] = w_issuing && (({1'b0, idx_q} + W1'(g)) < {1'b0, vl_q});
  end

  always_comb begin
    state_d   = state_q;
    aluop_d   = aluop_q;
    src_sel_d = src_sel_q;
    masked_d  = masked_q;
    vl_d      = vl_q;
    idx_d     = idx_q;
    illegal_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (!w_dec_legal) begin
            illegal_d = 1'b1;
          end else if (vl != '0) begin
            state_d   = S_ISSUE;
            aluop_d   = w_dec_aluop;
            src_sel_d = w_dec_src_sel;
            masked_d  = ~vm;  // vm = 0 selects a masked operation
            vl_d      = vl;
            idx_d     = '0;
          end
        end
      end
      S_ISSUE: begin
        if (out_ready) begin
          if (w_last) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + VL_W'(LANES);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      aluop_q   <= '0;
      src_sel_q <= '0;
      masked_q  <= 1'b0;
      vl_q      <= '0;
      idx_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      aluop_q   <= aluop_d;
      src_sel_q <= src_sel_d;
      masked_q  <= masked_d;
      vl_q      <= vl_d;
      idx_q     <= idx_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = w_issuing;
  assign out_aluop    = aluop_q;
  assign out_src_sel  = src_sel_q;
  assign out_masked   = masked_q;
  assign out_elem_idx = idx_q;
  assign out_lane_en  = w_lane_en;
  assign out_last     = w_issuing && w_last;
  assign illegal      = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_valu_issue_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_valu_issue_seq
// Brief  : Table-driven, directed and randomized checks of valu_issue_seq.
// Rev    : 1.0  initial release
// ============================================================================
module tb_valu_issue_seq;
  import valu_issue_seq_pkg::*;

  localparam int LANES = 4;
  localparam int VLEN  = 128;
  localparam int VL_W  = $clog2(VLEN) + 1;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct6;
  logic [2:0]       funct3;
  logic [VL_W-1:0]  vl;
  logic             vm;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_aluop;
  logic [1:0]       out_src_sel;
  logic             out_masked;
  logic [VL_W-1:0]  out_elem_idx;
  logic [LANES-1:0] out_lane_en;
  logic             out_last;
  logic             illegal;

  int tests  = 0;
  int failed = 0;

  valu_issue_seq #(.LANES(LANES), .VLEN(VLEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .funct6       (funct6),
    .funct3       (funct3),
    .vl           (vl),
    .vm           (vm),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_aluop    (out_aluop),
    .out_src_sel  (out_src_sel),
    .out_masked   (out_masked),
    .out_elem_idx (out_elem_idx),
    .out_lane_en  (out_lane_en),
    .out_last     (out_last),
    .illegal      (illegal)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference decode straight from the opcode table in the instruction set.
  logic [5:0] F6_TAB [8] = '{6'b000000, 6'b000010, 6'b001001, 6'b001010,
                             6'b001011, 6'b100101, 6'b101000, 6'b101001};
  logic [3:0] OP_TAB [8] = '{ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR,
                             ALUOP_XOR, ALUOP_SLL, ALUOP_SRL, ALUOP_SRA};

  task automatic ref_decode(input logic [5:0] f6, input logic [2:0] f3,
                            output bit legal, output logic [3:0] op, output logic [1:0] src);
    bit found = 1'b0;
    op = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (F6_TAB[i] == f6) begin
        found = 1'b1;
        op    = OP_TAB[i];
      end
    end
    src   = (f3 == 3'b100) ? 2'd1 : (f3 == 3'b011) ? 2'd2 : 2'd0;
    legal = found && (f3 == 3'b000 || f3 == 3'b100 || f3 == 3'b011)
            && !(f6 == 6'b000010 && f3 == 3'b011);
  endtask

  function automatic logic [LANES-1:0] exp_lanes(input int vlen_i, input int k);
    int n;
    n = vlen_i - k * LANES;
    exp_lanes = '0;
    for (int i = 0; i < LANES; i++) if (i < n) exp_lanes[i] = 1'b1;
  endfunction

  // Offers one instruction from IDLE and follows it to completion.
  task automatic run_instr(input logic [5:0] f6, input logic [2:0] f3, input int vlen_i,
                           input logic vm_i, input bit e_legal, input logic [3:0] e_op,
                           input logic [1:0] e_src, input int stall_first, input bit rnd_stall);
    int nbeats;
    int k;
    int stalls;
    int lead;
    bit rdy;
    logic [63:0] act;
    logic [63:0] exp;
    nbeats = e_legal ? (vlen_i + LANES - 1) / LANES : 0;
    check("ready_before_offer", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    funct6    = f6;
    funct3    = f3;
    vl        = VL_W'(vlen_i);
    vm        = vm_i;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    if (nbeats > 0) begin
      in_valid = 1'($urandom);
      funct6   = 6'($urandom);
      funct3   = 3'($urandom);
      vl       = VL_W'($urandom);
      vm       = 1'($urandom);
    end
    check("illegal_after_accept", 64'(illegal), 64'(!e_legal));
    if (nbeats == 0) begin
      check("no_beat_valid", 64'({out_valid, in_ready}), 64'b01);
      tick();
      check("quiet_next", 64'({illegal, out_valid, in_ready}), 64'b001);
      return;
    end
    k      = 0;
    stalls = 0;
    lead   = stall_first;
    while (k < nbeats) begin
      act = 64'({out_valid, in_ready, illegal, out_aluop, out_src_sel, out_masked,
                 out_elem_idx, out_lane_en, out_last});
      exp = 64'({1'b1, 1'b0, 1'b0, e_op, e_src, ~vm_i,
                 VL_W'(k * LANES), exp_lanes(vlen_i, k), (k == nbeats - 1)});
      check($sformatf("beat%0d", k), act, exp);
      if (lead > 0) begin
        rdy = 1'b0;
        lead--;
      end else if (rnd_stall && stalls < 3) begin
        rdy = ($urandom_range(0, 2) != 0);
      end else begin
        rdy = 1'b1;
      end
      out_ready = rdy;
      tick();
      if (rdy) begin
        k++;
        stalls = 0;
      end else begin
        stalls++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("done_idle", 64'({out_valid, out_last, in_ready}), 64'b001);
  endtask

  typedef struct {
    logic [5:0] f6;
    logic [2:0] f3;
    int         vlen;
    logic       vm;
    bit         legal;
    logic [3:0] op;
    logic [1:0] src;
    int         stall_first;
  } vec_t;

  vec_t tab [12];

  initial begin
    tab[0]  = '{6'b000000, 3'b000,  10, 1'b1, 1'b1, ALUOP_ADD, 2'd0, 0}; // vadd.vv
    tab[1]  = '{6'b101001, 3'b011,   4, 1'b0, 1'b1, ALUOP_SRA, 2'd2, 3}; // vsra.vi stalled
    tab[2]  = '{6'b111111, 3'b000,   8, 1'b1, 1'b0, 4'd0,      2'd0, 0};
    tab[3]  = '{6'b000010, 3'b011,   8, 1'b1, 1'b0, 4'd0,      2'd0, 0}; // vsub.vi
    tab[4]  = '{6'b001011, 3'b100,   0, 1'b1, 1'b1, ALUOP_XOR, 2'd1, 0}; // vl = 0
    tab[5]  = '{6'b000000, 3'b000, 128, 1'b1, 1'b1, ALUOP_ADD, 2'd0, 0}; // vl = VLEN
    tab[6]  = '{6'b100101, 3'b100,   5, 1'b0, 1'b1, ALUOP_SLL, 2'd1, 1};
    tab[7]  = '{6'b000010, 3'b100,   1, 1'b1, 1'b1, ALUOP_SUB, 2'd1, 0};
    tab[8]  = '{6'b001001, 3'b001,   8, 1'b1, 1'b0, 4'd0,      2'd0, 0}; // bad funct3
    tab[9]  = '{6'b101000, 3'b011, 127, 1'b0, 1'b1, ALUOP_SRL, 2'd2, 0};
    tab[10] = '{6'b001010, 3'b000,   3, 1'b1, 1'b1, ALUOP_OR,  2'd0, 2};
    tab[11] = '{6'b001001, 3'b011,   8, 1'b0, 1'b1, ALUOP_AND, 2'd2, 0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    funct6    = '0;
    funct3    = '0;
    vl        = '0;
    vm        = 1'b1;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_state", 64'({in_ready, out_valid, out_last, illegal, out_elem_idx,
                              out_lane_en, out_aluop, out_src_sel, out_masked}),
          64'({1'b1, 1'b0, 1'b0, 1'b0, VL_W'(0), LANES'(0), 4'd0, 2'd0, 1'b0}));
    reset = 1'b0;
    tick();

    foreach (tab[i]) begin
      run_instr(tab[i].f6, tab[i].f3, tab[i].vlen, tab[i].vm, tab[i].legal,
                tab[i].op, tab[i].src, tab[i].stall_first, 1'b0);
    end

    // Reset in the middle of a vl=16 instruction abandons it.
    in_valid  = 1'b1;
    funct6    = FUNCT6_VADD;
    funct3    = FUNCT3_OPIVV;
    vl        = VL_W'(16);
    vm        = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rst_seq_beat1", 64'({out_valid, out_elem_idx}), 64'({1'b1, VL_W'(0)}));
    tick();
    check("rst_seq_beat2", 64'({out_valid, out_elem_idx}), 64'({1'b1, VL_W'(4)}));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_seq_cleared", 64'({in_ready, out_valid, out_last, out_elem_idx, out_lane_en}),
          64'({1'b1, 1'b0, 1'b0, VL_W'(0), LANES'(0)}));
    tick();
    check("rst_seq_idle", 64'({in_ready, out_valid}), 64'b10);
    out_ready = 1'b0;
    run_instr(FUNCT6_VAND, FUNCT3_OPIVV, 4, 1'b1, 1'b1, ALUOP_AND, 2'd0, 0, 1'b0);

    // Randomized instructions against the reference decode.
    for (int n = 0; n < 40; n++) begin
      logic [5:0] f6;
      logic [2:0] f3;
      int         vlen_r;
      bit         lg;
      logic [3:0] op;
      logic [1:0] src;
      f6 = ($urandom_range(0, 9) < 8) ? F6_TAB[$urandom_range(0, 7)] : 6'($urandom);
      case ($urandom_range(0, 3))
        0:       f3 = 3'b000;
        1:       f3 = 3'b100;
        2:       f3 = 3'b011;
        default: f3 = 3'($urandom);
      endcase
      vlen_r = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, VLEN);
      ref_decode(f6, f3, lg, op, src);
      run_instr(f6, f3, vlen_r, 1'($urandom), lg, op, src, $urandom_range(0, 2), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
